uart_device: RTL

- Memory-mapped UART responder that sits on the far (device) end of the Aquila M_DEVICE master port, in the uncached 0xC000_0000 device segment.
- Decodes single-beat strobe/rw requests and answers with a one-cycle data_ready pulse.
- Serialises bytes from a TX FIFO onto uart_tx_o (8N1).
- Deserialises uart_rx_i into an RX FIFO.

---
 rtl/uart_device_pkg.sv | 34 +++
 rtl/uart_device_sync_fifo.sv | 52 +++++
 rtl/uart_device.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_device_pkg.sv
// ---------------------------------------------------------------------------
// uart_device_pkg : register offsets, STATUS bits and FSM encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_device_pkg;

  localparam int DIV_W = 16;

  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_BAUD   = 3'd3;
  localparam logic [2:0] OFF_IRQ_EN = 3'd4;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_OVF    = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_device_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, extra pointer MSB separates full from empty.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_device.sv
// ---------------------------------------------------------------------------
// uart_device : memory-mapped 8N1 UART with TX/RX FIFOs on the device bus.
// Optional interrupt logic under `UART_DEVICE_IRQ_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_device
  import uart_device_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]   S_DEVICE_addr_i,
  input  logic              S_DEVICE_rw_i,
  input  logic [XLEN/8-1:0] S_DEVICE_byte_enable_i,
  input  logic [XLEN-1:0]   S_DEVICE_data_i,
  output logic              S_DEVICE_data_ready_o,
  output logic [XLEN-1:0]   S_DEVICE_data_o,
  output logic              uart_tx_o,
  input  logic              uart_rx_i,
  output logic              irq_o
);

  logic [2:0]       off;
  logic             rd;
  logic             wr;
  logic [XLEN-1:0]  rdata;
  logic [DIV_W-1:0] baud_div;
  logic             tx_ovf, rx_ovr, frame_err;
  logic [6:0]       status;
  logic             status_clr;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_dout;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_dout;
  logic             tx_ovf_evt, rx_ovr_evt, frame_evt;

  uart_state_e      tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  uart_state_e      rx_state;
  logic [DIV_W-1:0] rx_cnt, rx_div;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_s1, rx_s2, rx_prev, rx_wait;

  logic             unused;
  assign unused = ^{S_DEVICE_addr_i[XLEN-1:6], S_DEVICE_addr_i[2:0],
                    S_DEVICE_data_i[XLEN-1:16], S_DEVICE_byte_enable_i[XLEN/8-1:2]};

  assign off = S_DEVICE_addr_i[5:3];
  assign rd  = S_DEVICE_strobe_i & ~S_DEVICE_rw_i;
  assign wr  = S_DEVICE_strobe_i &  S_DEVICE_rw_i;

  assign tx_push    = wr & (off == OFF_TXDATA) & S_DEVICE_byte_enable_i[0];
  assign tx_pop     = (tx_state == S_IDLE) & ~tx_empty;
  assign rx_pop     = rd & (off == OFF_RXDATA) & ~rx_empty;
  assign status_clr = rd & (off == OFF_STATUS);
  assign tx_ovf_evt = tx_push & tx_full & ~tx_pop;
  assign rx_ovr_evt = rx_push & rx_full & ~rx_pop;

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_RX_OVR]    = rx_ovr;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_TX_OVF]    = tx_ovf;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i (clk_i), .rst_ni (rst_ni), .push (tx_push), .pop (tx_pop),
    .din (S_DEVICE_data_i[7:0]), .full (tx_full), .empty (tx_empty), .dout (tx_dout)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i (clk_i), .rst_ni (rst_ni), .push (rx_push), .pop (rx_pop),
    .din (rx_shift), .full (rx_full), .empty (rx_empty), .dout (rx_dout)
  );

`ifdef UART_DEVICE_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (wr && (off == OFF_IRQ_EN) && S_DEVICE_byte_enable_i[0])
        irq_en <= S_DEVICE_data_i[1:0];
      irq_o <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty & (tx_state == S_IDLE));
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_TXDATA: rdata[0] = tx_full;
        OFF_RXDATA: begin
          if (rx_empty) rdata[31]  = 1'b1;
          else          rdata[7:0] = rx_dout;
        end
        OFF_STATUS: rdata[6:0] = status;
        OFF_BAUD:   rdata[DIV_W-1:0] = baud_div;
`ifdef UART_DEVICE_IRQ_EN
        OFF_IRQ_EN: rdata[1:0] = irq_en;
`endif
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      S_DEVICE_data_ready_o <= 1'b0;
      S_DEVICE_data_o       <= '0;
      baud_div              <= DIV_W'(DEFAULT_DIV);
      tx_ovf                <= 1'b0;
      rx_ovr                <= 1'b0;
      frame_err             <= 1'b0;
    end else begin
      S_DEVICE_data_ready_o <= S_DEVICE_strobe_i;
      S_DEVICE_data_o       <= rdata;
      if (wr && (off == OFF_BAUD)) begin
        if (S_DEVICE_byte_enable_i[0]) baud_div[7:0]  <= S_DEVICE_data_i[7:0];
        if (S_DEVICE_byte_enable_i[1]) baud_div[15:8] <= S_DEVICE_data_i[15:8];
      end
      // A sticky event coinciding with the clearing read wins.
      tx_ovf    <= (tx_ovf    & ~status_clr) | tx_ovf_evt;
      rx_ovr    <= (rx_ovr    & ~status_clr) | rx_ovr_evt;
      frame_err <= (frame_err & ~status_clr) | frame_evt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          uart_tx_o <= 1'b1;
          if (!tx_empty) begin
            tx_shift  <= tx_dout;
            tx_cnt    <= '0;
            tx_div    <= baud_div;
            uart_tx_o <= 1'b0;
            tx_state  <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == tx_div) begin
            tx_cnt    <= '0;
            tx_div    <= baud_div;
            tx_bit    <= '0;
            uart_tx_o <= tx_shift[0];
            tx_state  <= S_DATA;
          end else tx_cnt <= tx_cnt + DIV_W'(1);
        end
        S_DATA: begin
          if (tx_cnt == tx_div) begin
            tx_cnt <= '0;
            tx_div <= baud_div;
            if (tx_bit == 3'd7) begin
              uart_tx_o <= 1'b1;
              tx_state  <= S_STOP;
            end else begin
              tx_bit    <= tx_bit + 3'd1;
              tx_shift  <= {1'b0, tx_shift[7:1]};
              uart_tx_o <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + DIV_W'(1);
        end
        S_STOP: begin
          if (tx_cnt == tx_div) tx_state <= S_IDLE;
          else                  tx_cnt   <= tx_cnt + DIV_W'(1);
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // RX samples the synchronised line at mid-bit: half a period after the start edge, then every period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_div    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_wait   <= 1'b0;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rx_s1     <= uart_rx_i;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_div   <= baud_div;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == (rx_div >> 1)) begin
            rx_cnt   <= '0;
            rx_div   <= baud_div;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + DIV_W'(1);
        end
        S_DATA: begin
          if (rx_cnt == rx_div) begin
            rx_cnt   <= '0;
            rx_div   <= baud_div;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + DIV_W'(1);
        end
        S_STOP: begin
          if (rx_wait) begin
            if (rx_s2) begin
              rx_wait  <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_cnt == rx_div) begin
            if (rx_s2) begin
              rx_push  <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              frame_evt <= 1'b1;
              rx_wait   <= 1'b1;
            end
          end else rx_cnt <= rx_cnt + DIV_W'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
